// File: rtl/alu_ctrl_fsm_if.sv
// alu_ctrl_fsm_if: fetch handshake, ALU control, memory and PC strobes for the sequencer
//   master: fetch/datapath side (drives instruction, ALU zero flag, memory ready)
//   slave : sequencer side (drives instr_ready, ALU/regfile/memory/PC controls)
interface alu_ctrl_fsm_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_cnt;
  logic        alu_src_imm;
  logic        alu_iszero;
  logic        reg_we;
  logic        reg_dst_rt;
  logic        wb_from_mem;
  logic        mem_re;
  logic        mem_we;
  logic        mem_ready;
  logic [1:0]  pc_sel;
  logic        pc_upd;
  logic        illegal;
  logic        mem_err;
  modport master (
    output instr_valid, instr, alu_iszero, mem_ready,
    input  instr_ready, alu_cnt, alu_src_imm, reg_we, reg_dst_rt, wb_from_mem,
           mem_re, mem_we, pc_sel, pc_upd, illegal, mem_err
  );
  modport slave (
    input  instr_valid, instr, alu_iszero, mem_ready,
    output instr_ready, alu_cnt, alu_src_imm, reg_we, reg_dst_rt, wb_from_mem,
           mem_re, mem_we, pc_sel, pc_upd, illegal, mem_err
  );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multicycle DECODE/EXEC/MEM/WB sequencer driving a 16-bit ALU, regfile, data memory and PC
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch valid/ready + instr in; alu_cnt/alu_src_imm out, alu_iszero in;
//              reg_we/reg_dst_rt/wb_from_mem, mem_re/mem_we with mem_ready, pc_sel/pc_upd, illegal/mem_err out
module alu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPC_W       = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_ctrl_fsm_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, ABORT = 3'd5;
  localparam logic [OPC_W-1:0] OP_R = 0, OP_ADDI = 1, OP_LW = 2, OP_SW = 3, OP_BEQ = 4, OP_BNE = 5, OP_JMP = 6;
  logic [2:0]       state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [2:0]       funct_q, funct_d;
  logic [2:0]       alu_cnt_q, alu_cnt_d;
  logic             src_imm_q, src_imm_d;
  logic             dst_rt_q, dst_rt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             is_br, is_mem, taken;
  assign is_br  = op_q == OP_BEQ || op_q == OP_BNE;
  assign is_mem = op_q == OP_LW || op_q == OP_SW;
  assign taken  = op_q == OP_BEQ ? bus.alu_iszero : !bus.alu_iszero;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    alu_cnt_d = alu_cnt_q;
    src_imm_d = src_imm_q;
    dst_rt_d  = dst_rt_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        op_d    = bus.instr[15:16-OPC_W];
        funct_d = bus.instr[2:0];
        state_d = DECODE;
      end
      DECODE: begin
        alu_cnt_d = op_q == OP_R ? funct_q : is_br ? 3'd1 : 3'd0;
        src_imm_d = op_q == OP_ADDI || is_mem;
        dst_rt_d  = op_q == OP_ADDI || op_q == OP_LW;
        state_d   = op_q >= OP_JMP ? IDLE : EXEC;
      end
      EXEC: begin
        cnt_d   = '0;
        state_d = is_br ? IDLE : is_mem ? MEM : WB;
      end
      MEM: if (bus.mem_ready) state_d = op_q == OP_LW ? WB : IDLE;
      else begin
        cnt_d = cnt_q + 8'd1;
        // abort gets its own cycle so the request is already dropped when mem_err pulses
        if (cnt_q + 8'd1 == 8'(MEM_TIMEOUT)) state_d = ABORT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      funct_q   <= '0;
      alu_cnt_q <= '0;
      src_imm_q <= 1'b0;
      dst_rt_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      alu_cnt_q <= alu_cnt_d;
      src_imm_q <= src_imm_d;
      dst_rt_q  <= dst_rt_d;
      cnt_q     <= cnt_d;
    end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.alu_cnt     = alu_cnt_q;
  assign bus.alu_src_imm = src_imm_q;
  assign bus.reg_dst_rt  = dst_rt_q;
  assign bus.reg_we      = state_q == WB;
  assign bus.wb_from_mem = state_q == WB && op_q == OP_LW;
  assign bus.mem_re      = state_q == MEM && op_q == OP_LW;
  assign bus.mem_we      = state_q == MEM && op_q == OP_SW;
  assign bus.illegal     = state_q == DECODE && op_q > OP_JMP;
  assign bus.mem_err     = state_q == ABORT;
  assign bus.pc_upd      = (state_q == DECODE && op_q >= OP_JMP) || (state_q == EXEC && is_br) ||
                           (state_q == MEM && op_q == OP_SW && bus.mem_ready) || state_q == WB || state_q == ABORT;
  assign bus.pc_sel      = state_q == DECODE && op_q == OP_JMP ? 2'd2 :
                           state_q == EXEC && is_br && taken ? 2'd1 : 2'd0;
endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle control sequencer that issues operations to the 16-bit ALU: opcode selection on alu_cnt, operand-B source selection, and result consumption via iszero.
- Accepts one 16-bit instruction at a time from fetch through a valid/ready handshake.
- Steps the instruction through DECODE/EXEC/MEM/WB.
- Drives register-file, data-memory and PC-select strobes, with a bounded wait on data memory.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for mem_ready in MEM before abort; range 1..255.
- OPC_W, 4: opcode field width, taken from instr[15:12]; fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  fetch presents an instruction
- instr  input  16  instruction word: [15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] funct
- instr_ready  output  1  sequencer can accept; equals (state==IDLE)
- alu_cnt  output  3  ALU operation code: 0 add, 1 sub, 2 not, 3 shl, 4 shr, 5 and, 6 or, 7 slt
- alu_src_imm  output  1  1: ALU B = sign-extended instr[5:0]; 0: B = rt register
- alu_iszero  input  1  ALU zero flag, sampled in EXEC
- reg_we  output  1  register-file write strobe (WB); one cycle
- reg_dst_rt  output  1  1: write rt; 0: write rd
- wb_from_mem  output  1  1: writeback data from memory; 0: from ALU
- mem_re  output  1  data-memory read request, held in MEM
- mem_we  output  1  data-memory write request, held in MEM
- mem_ready  input  1  memory completes the request this cycle
- pc_sel  output  2  0: PC+1; 1: branch target; 2: jump target. Valid on the cycle pc_upd=1.
- pc_upd  output  1  one-cycle PC update strobe at instruction retire
- illegal  output  1  one-cycle pulse on an undefined opcode
- mem_err  output  1  one-cycle pulse on a MEM timeout

Behaviour:
- Reset: asynchronous; state=IDLE. All outputs reset to 0 except instr_ready=1; timeout counter=0; latched instruction=0.
- Handshake: transfer occurs when instr_valid && instr_ready at a clk edge. instr is latched then, and state goes to DECODE. instr_valid without ready is ignored; fetch holds it.
- alu_cnt, alu_src_imm and reg_dst_rt are registered in DECODE and stay stable through EXEC/MEM/WB.
- Opcode 0, R-type: alu_cnt = funct; src_imm=0; path DECODE -> EXEC -> WB; writes rd.
- Opcode 1, ADDI: alu_cnt=0; src_imm=1; path EXEC -> WB; writes rt.
- Opcode 2, LW: alu_cnt=0; src_imm=1; path EXEC -> MEM(read) -> WB; wb_from_mem=1; writes rt.
- Opcode 3, SW: alu_cnt=0; src_imm=1; path EXEC -> MEM(write); retires from MEM.
- Opcode 4, BEQ: alu_cnt=1; src_imm=0; taken if alu_iszero=1 in EXEC; retires from EXEC.
- Opcode 5, BNE: alu_cnt=1; src_imm=0; taken if alu_iszero=0 in EXEC; retires from EXEC.
- Opcode 6, JMP: no ALU use; alu_cnt=0; retires from DECODE with pc_sel=2.
- Opcodes 7..15: illegal pulses in DECODE; pc_upd=1 with pc_sel=0; return to IDLE.
- Retire: the last state asserts pc_upd for exactly one cycle, then returns to IDLE.
  - pc_sel=1 only for a taken branch; otherwise 0, except JMP (2).
- Latency (accept edge = cycle 0, next cycle 1):
  - JMP and illegal: retire in cycle 1.
  - Branch: retire in cycle 2.
  - R/ADDI: reg_we in cycle 3.
  - LW/SW: MEM entered in cycle 3; LW reg_we one cycle after the mem_ready cycle, SW retires in the mem_ready cycle.
  - instr_ready returns the cycle after retire.
- MEM wait:
  - The counter clears on MEM entry and increments each cycle mem_ready=0.
  - mem_ready=1 completes the request, even on the cycle the count reaches MEM_TIMEOUT.
  - Count reaching MEM_TIMEOUT with mem_ready=0: pulse mem_err, drop mem_re/mem_we, pc_upd with pc_sel=0, no reg_we, go to IDLE.
  - mem_re/mem_we never overlap and are 0 outside MEM.
- reg_we and mem_we are never asserted in the same cycle.
- Reset asserted mid-instruction aborts immediately; no strobe completes.

Test Plan:
- R-type instr=0x0A2D (rs=5, rt=0, rd=5, funct=5), valid held -> alu_cnt=5, src_imm=0; reg_we=1, reg_dst_rt=0 in cycle 3; pc_upd with pc_sel=0; instr_ready=1 in cycle 4.
- BEQ 0x4000 with alu_iszero=1 in EXEC -> pc_upd=1, pc_sel=1 in cycle 2, no reg_we. Repeat with iszero=0 -> pc_sel=0. BNE 0x5000 with iszero=0 -> pc_sel=1.
- LW 0x2000, mem_ready low 3 cycles then high -> mem_re=1 for 4 cycles, then reg_we=1 with wb_from_mem=1 and reg_dst_rt=1; mem_err never pulses.
- SW 0x3000, mem_ready held 0 -> mem_err pulses after exactly MEM_TIMEOUT=15 MEM cycles; mem_we drops; no reg_we; IDLE next cycle. Separately, mem_ready on the 15th cycle completes with no error.
- Opcode 0xF (instr=0xF000) -> illegal pulse in cycle 1 with pc_upd=1, pc_sel=0. JMP 0x6000 -> pc_sel=2 in cycle 1.
- Assert rst during MEM of LW -> all strobes 0 and instr_ready=1 asynchronously. Back-to-back instr_valid after release -> the next instruction is accepted only when instr_ready=1.
